// File: rtl/ring_network.sv
// Unidirectional ring interconnect: one slot register per stop, one hop per
// cycle, in-transit flits win over injections, and a full ejection FIFO
// deflects the arriving flit for another lap instead of dropping it.

// Per-stop ejection FIFO holding {payload, source ID}.
module ring_ej_fifo #(
  parameter int WIDTH = 32,
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic [ID_W-1:0]  push_src_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [ID_W-1:0]  src_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH+ID_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_push;
  logic                  do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never frees room for a push.
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && valid_o;
  assign {data_o, src_o} = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; cleared on reset so an empty FIFO presents a zero head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= {push_data_i, push_src_i};
    end
  end
endmodule

module ring_network #(
  parameter int NODES = 9,
  parameter int WIDTH = 32,
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [NODES-1:0]      inj_valid_i,
  input  logic [NODES*ID_W-1:0] inj_dest_i,
  input  logic [NODES*WIDTH-1:0] inj_data_i,
  output logic [NODES-1:0]      inj_ready_o,
  output logic [NODES-1:0]      ej_valid_o,
  output logic [NODES*WIDTH-1:0] ej_data_o,
  output logic [NODES*ID_W-1:0] ej_src_o,
  input  logic [NODES-1:0]      ej_ready_i,
  output logic [15:0]           bad_dest_cnt_o
);
  typedef struct packed {
    logic             vld;
    logic [ID_W-1:0]  dst;
    logic [ID_W-1:0]  src;
    logic [WIDTH-1:0] data;
  } slot_t;

  slot_t            slot_q [NODES];
  slot_t            slot_d [NODES];
  logic [NODES-1:0] hit;
  logic [NODES-1:0] push;
  logic [NODES-1:0] slot_free;
  logic [NODES-1:0] inj_bad;
  logic [NODES-1:0] bad_fire;
  logic [NODES-1:0] fifo_full;
  logic [NODES-1:0] fifo_valid;
  logic [15:0]      bad_cnt_q, bad_cnt_d;
  logic [16:0]      bad_sum;
  logic [16:0]      bad_tot;

  // Stop i is fed by the slot leaving its upstream neighbour.
  function automatic int prev_node(input int n);
    return (n == 0) ? NODES - 1 : n - 1;
  endfunction

  // Per-stop arbitration: eject when addressed and there is room, and offer
  // the slot to the local injector only when nothing is passing through.
  always_comb begin
    hit       = '0;
    push      = '0;
    slot_free = '0;
    inj_bad   = '0;
    for (int i = 0; i < NODES; i++) begin
      hit[i]       = enable_i && slot_q[prev_node(i)].vld &&
                     (slot_q[prev_node(i)].dst == ID_W'(i));
      push[i]      = hit[i] && !fifo_full[i];
      slot_free[i] = enable_i && (!slot_q[prev_node(i)].vld || push[i]);
      inj_bad[i]   = 32'(inj_dest_i[i*ID_W +: ID_W]) >= NODES;
    end
  end

  assign inj_ready_o = slot_free;

  // Slot next-state: pass/deflect the incoming flit, else take a new one.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      slot_d[i]   = slot_q[i];
      bad_fire[i] = 1'b0;
      if (enable_i) begin
        if (!slot_free[i]) begin
          slot_d[i] = slot_q[prev_node(i)];
        end else if (inj_valid_i[i] && !inj_bad[i]) begin
          slot_d[i].vld  = 1'b1;
          slot_d[i].dst  = inj_dest_i[i*ID_W +: ID_W];
          slot_d[i].src  = ID_W'(i);
          slot_d[i].data = inj_data_i[i*WIDTH +: WIDTH];
        end else begin
          slot_d[i].vld = 1'b0;
          bad_fire[i]   = inj_valid_i[i] && inj_bad[i];
        end
      end
    end
  end

  // Ring slot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NODES; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NODES; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Several stops may discard a bad-destination flit in one cycle.
  always_comb begin
    bad_sum = '0;
    for (int i = 0; i < NODES; i++) bad_sum = bad_sum + 17'(bad_fire[i]);
    bad_tot   = {1'b0, bad_cnt_q} + bad_sum;
    bad_cnt_d = bad_tot[16] ? 16'hFFFF : bad_tot[15:0];
  end

  // Saturating bad-destination counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bad_cnt_q <= '0;
    else         bad_cnt_q <= bad_cnt_d;
  end

  assign bad_dest_cnt_o = bad_cnt_q;
  assign ej_valid_o     = fifo_valid;

  for (genvar g = 0; g < NODES; g++) begin : g_ej
    ring_ej_fifo #(
      .WIDTH(WIDTH),
      .ID_W (ID_W),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (push[g]),
      .push_data_i(slot_q[prev_node(g)].data),
      .push_src_i (slot_q[prev_node(g)].src),
      .pop_i      (ej_ready_i[g]),
      .full_o     (fifo_full[g]),
      .valid_o    (fifo_valid[g]),
      .data_o     (ej_data_o[g*WIDTH +: WIDTH]),
      .src_o      (ej_src_o[g*ID_W +: ID_W])
    );
  end
endmodule
